// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // Baud ticks per serial bit.
  localparam int unsigned OVERSAMPLE = 16;

  // Baud Rate Divider values for a 50 MHz system clock, format [31:6].[5:0].
  localparam logic [31:0] BRD_230400 = 32'h364;
  localparam logic [31:0] BRD_115200 = 32'h6C8;
  localparam logic [31:0] BRD_57600  = 32'hD90;
  localparam logic [31:0] BRD_28800  = 32'h1B20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    ALIGN  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

  // True for every state that belongs to a frame (generator running).
  function automatic logic in_frame(input tx_state_e s);
    return (s == ALIGN) || (s == START) || (s == DATA) ||
           (s == PARITY) || (s == STOP);
  endfunction

  // True for states whose duration is measured in baud ticks.
  function automatic logic is_bit_state(input tx_state_e s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage

// File: rtl/baud_tick_detect.sv
// Synchronises the free-running baud clock into the system domain and
// turns each rising edge into a registered one-cycle tick.
module baud_tick_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic baud_i,
  output logic tick_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic tick_q;

  // Two-flop synchroniser, edge history and registered tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= baud_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: owns the baud generator configuration and run
// control, and serialises one character per handshake onto txd.
module uart_tx_sequencer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter logic [31:0] RESET_BRD  = uart_pkg::BRD_115200
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 cfg_we,
  input  logic [31:0]          cfg_brd,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 baud_in,
  output logic                 brg_enable,
  output logic                 brg_reset_n,
  output logic [31:0]          brg_brd,
  output logic                 txd,
  output logic                 busy,
  output logic                 cfg_err
);

  import uart_pkg::*;

  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic tick;

  tx_state_e state_q, state_d;

  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [31:0]          brd_q, brd_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;

  logic txd_q, txd_d;
  logic tx_ready_q, tx_ready_d;
  logic busy_q, busy_d;
  logic cfg_err_q, cfg_err_d;
  logic brg_enable_q, brg_enable_d;
  logic brg_reset_n_q, brg_reset_n_d;

  logic bit_done;

  baud_tick_detect u_tick (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .baud_i (baud_in),
    .tick_o (tick)
  );

  assign bit_done = tick && is_bit_state(state_q) && (tick_cnt_q == TICK_LAST);

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath: frame sequencing, tick/bit counting, config latch.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    brd_d      = brd_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;

    unique case (state_q)
      IDLE: begin
        if (cfg_we) begin
          brd_d     = cfg_brd;
          par_en_d  = cfg_parity_en;
          par_odd_d = cfg_parity_odd;
          stop2_d   = cfg_stop2;
          state_d   = CFG;
        end else if (tx_valid && tx_ready_q) begin
          shift_d = tx_data;
          par_d   = par_odd_q ^ (^tx_data);
          state_d = ALIGN;
        end
      end
      CFG:   state_d = IDLE;
      ALIGN: state_d = START;
      START: begin
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state entry and at every bit boundary, so a
    // second stop bit reuses STOP without a separate state.
    if ((state_d != state_q) || bit_done) begin
      tick_cnt_d = '0;
    end else if (tick && is_bit_state(state_q)) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // Datapath and configuration registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      brd_q      <= RESET_BRD;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      brd_q      <= brd_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
    end
  end

  // Output decode from the next state so every output is registered yet
  // changes in the same cycle the state does.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_q;
      default: txd_d = 1'b1;
    endcase
    tx_ready_d    = (state_d == IDLE);
    busy_d        = in_frame(state_d);
    brg_enable_d  = in_frame(state_d);
    brg_reset_n_d = !((state_d == CFG) || (state_d == ALIGN));
    cfg_err_d     = cfg_we && (state_q != IDLE);
  end

  // Output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      txd_q         <= 1'b1;
      tx_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      brg_enable_q  <= 1'b0;
      brg_reset_n_q <= 1'b0;
    end else begin
      txd_q         <= txd_d;
      tx_ready_q    <= tx_ready_d;
      busy_q        <= busy_d;
      cfg_err_q     <= cfg_err_d;
      brg_enable_q  <= brg_enable_d;
      brg_reset_n_q <= brg_reset_n_d;
    end
  end

  assign txd         = txd_q;
  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign cfg_err     = cfg_err_q;
  assign brg_enable  = brg_enable_q;
  assign brg_reset_n = brg_reset_n_q;
  assign brg_brd     = brd_q;

endmodule
